// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM port arbiter: MCU single-pixel access (priority) and a rectangle-fill engine.
// States: IDLE | no fill pending   FILL | fill pending   RD_WAIT1/2 | MCU read pipeline
module vga_fb_arbiter #(
  parameter int H_PIX    = 160,
  parameter int V_PIX    = 120,
  parameter int COL_BITS = 8,
  parameter int ROW_BITS = 7,
  parameter int CW       = 12
) (
  input  logic                         CLK_50MHz,
  input  logic                         RST_N,
  input  logic                         MCU_REQ,
  input  logic                         MCU_WE,
  input  logic [COL_BITS-1:0]          MCU_X,
  input  logic [ROW_BITS-1:0]          MCU_Y,
  input  logic [CW-1:0]                MCU_WD,
  output logic                         MCU_ACK,
  output logic [CW-1:0]                MCU_RD,
  output logic                         MCU_RD_VALID,
  input  logic                         FILL_START,
  input  logic [COL_BITS-1:0]          FILL_X0,
  input  logic [COL_BITS-1:0]          FILL_X1,
  input  logic [ROW_BITS-1:0]          FILL_Y0,
  input  logic [ROW_BITS-1:0]          FILL_Y1,
  input  logic [CW-1:0]                FILL_COLOR,
  output logic                         FILL_BUSY,
  output logic                         FILL_DONE,
  output logic                         FB_WE,
  output logic [COL_BITS+ROW_BITS-1:0] FB_WA1,
  output logic [CW-1:0]                FB_WD,
  input  logic [CW-1:0]                FB_RD1
);
  localparam int AW = COL_BITS + ROW_BITS;
  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_FILL     = 2'd1;
  localparam logic [1:0] S_RD_WAIT1 = 2'd2;
  localparam logic [1:0] S_RD_WAIT2 = 2'd3;
  localparam logic [COL_BITS-1:0] X_MAX = COL_BITS'(H_PIX - 1);
  localparam logic [ROW_BITS-1:0] Y_MAX = ROW_BITS'(V_PIX - 1);

  logic [1:0]          state_q, state_d;
  logic                busy_q, busy_d, fin_q, fin_d, done_q, done_d;
  logic                ack_q, ack_d, we_q, we_d, rdv_q, rdv_d, oor_q, oor_d;
  logic [AW-1:0]       wa_q, wa_d;
  logic [CW-1:0]       wd_q, wd_d, rd_q, rd_d, col_q, col_d;
  logic [COL_BITS-1:0] x0_q, x0_d, x1_q, x1_d, cx_q, cx_d;
  logic [ROW_BITS-1:0] y0_q, y0_d, y1_q, y1_d, cy_q, cy_d;

  logic [COL_BITS-1:0] fx0, fx1, ex0, ex1, cx_e;
  logic [ROW_BITS-1:0] fy0, fy1, ey1, cy_e;
  logic [CW-1:0]       col_e;
  logic                fill_ok, start_acc, start_go, can_grant, grant, mcu_oor, fill_wr;

  assign fx0 = (FILL_X0 > X_MAX) ? X_MAX : FILL_X0;
  assign fx1 = (FILL_X1 > X_MAX) ? X_MAX : FILL_X1;
  assign fy0 = (FILL_Y0 > Y_MAX) ? Y_MAX : FILL_Y0;
  assign fy1 = (FILL_Y1 > Y_MAX) ? Y_MAX : FILL_Y1;
  assign fill_ok   = (fx0 <= fx1) && (fy0 <= fy1);
  assign start_acc = FILL_START && !busy_q;
  assign start_go  = start_acc && fill_ok;
  assign can_grant = (state_q == S_IDLE) || (state_q == S_FILL);
  assign grant     = can_grant && MCU_REQ;
  assign mcu_oor   = (32'(MCU_X) >= 32'(H_PIX)) || (32'(MCU_Y) >= 32'(V_PIX));
  assign fill_wr   = can_grant && !MCU_REQ && !fin_q && (busy_q || start_go);

  // On the start edge the first pixel is written straight from the clamped inputs.
  assign ex0   = start_go ? fx0 : x0_q;
  assign ex1   = start_go ? fx1 : x1_q;
  assign ey1   = start_go ? fy1 : y1_q;
  assign cx_e  = start_go ? fx0 : cx_q;
  assign cy_e  = start_go ? fy0 : cy_q;
  assign col_e = start_go ? FILL_COLOR : col_q;

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    fin_d   = 1'b0;
    done_d  = 1'b0;
    ack_d   = 1'b0;
    we_d    = 1'b0;
    rdv_d   = 1'b0;
    oor_d   = oor_q;
    wa_d    = wa_q;
    wd_d    = wd_q;
    rd_d    = rd_q;
    col_d   = col_q;
    x0_d    = x0_q;
    x1_d    = x1_q;
    y0_d    = y0_q;
    y1_d    = y1_q;
    cx_d    = cx_q;
    cy_d    = cy_q;

    if (fin_q) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end

    if (start_acc) begin
      x0_d  = fx0;
      x1_d  = fx1;
      y0_d  = fy0;
      y1_d  = fy1;
      col_d = FILL_COLOR;
      cx_d  = fx0;
      cy_d  = fy0;
      if (fill_ok) busy_d = 1'b1;
      else         done_d = 1'b1;
    end

    if (grant) begin
      ack_d = 1'b1;
      wa_d  = {MCU_Y, MCU_X};
      if (MCU_WE) begin
        we_d = !mcu_oor;
        wd_d = MCU_WD;
      end else begin
        oor_d = mcu_oor;
      end
    end else if (fill_wr) begin
      we_d = 1'b1;
      wa_d = {cy_e, cx_e};
      wd_d = col_e;
      if (cx_e == ex1 && cy_e == ey1) begin
        fin_d = 1'b1;
      end else if (cx_e == ex1) begin
        cx_d = ex0;
        cy_d = cy_e + ROW_BITS'(1);
      end else begin
        cx_d = cx_e + COL_BITS'(1);
      end
    end

    if (state_q == S_RD_WAIT2) begin
      rd_d  = oor_q ? '0 : FB_RD1;
      rdv_d = 1'b1;
    end

    if (grant && !MCU_WE)          state_d = S_RD_WAIT1;
    else if (state_q == S_RD_WAIT1) state_d = S_RD_WAIT2;
    else                           state_d = busy_d ? S_FILL : S_IDLE;
  end

  always_ff @(posedge CLK_50MHz or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
      we_q    <= 1'b0;
      rdv_q   <= 1'b0;
      oor_q   <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
      rd_q    <= '0;
      col_q   <= '0;
      x0_q    <= '0;
      x1_q    <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      fin_q   <= fin_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
      we_q    <= we_d;
      rdv_q   <= rdv_d;
      oor_q   <= oor_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      rd_q    <= rd_d;
      col_q   <= col_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      y0_q    <= y0_d;
      y1_q    <= y1_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
    end
  end

  assign MCU_ACK      = ack_q;
  assign MCU_RD       = rd_q;
  assign MCU_RD_VALID = rdv_q;
  assign FILL_BUSY    = busy_q;
  assign FILL_DONE    = done_q;
  assign FB_WE        = we_q;
  assign FB_WA1       = wa_q;
  assign FB_WD        = wd_q;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: queue-based pixel model checked every cycle, plus directed literal checks.
module tb_vga_fb_arbiter;
  localparam int CW = 12;
  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mcu_req = 1'b0, mcu_we = 1'b0;
  logic [7:0]    mcu_x = '0;
  logic [6:0]    mcu_y = '0;
  logic [CW-1:0] mcu_wd = '0;
  logic          mcu_ack, mcu_rd_valid;
  logic [CW-1:0] mcu_rd;
  logic          fill_start = 1'b0;
  logic [7:0]    fill_x0 = '0, fill_x1 = '0;
  logic [6:0]    fill_y0 = '0, fill_y1 = '0;
  logic [CW-1:0] fill_color = '0;
  logic          fill_busy, fill_done, fb_we;
  logic [AW-1:0] fb_wa1;
  logic [CW-1:0] fb_wd;
  logic [CW-1:0] fb_rd1 = '0;

  always #5 clk = ~clk;

  vga_fb_arbiter dut (
    .CLK_50MHz(clk), .RST_N(rst_n),
    .MCU_REQ(mcu_req), .MCU_WE(mcu_we), .MCU_X(mcu_x), .MCU_Y(mcu_y), .MCU_WD(mcu_wd),
    .MCU_ACK(mcu_ack), .MCU_RD(mcu_rd), .MCU_RD_VALID(mcu_rd_valid),
    .FILL_START(fill_start), .FILL_X0(fill_x0), .FILL_X1(fill_x1),
    .FILL_Y0(fill_y0), .FILL_Y1(fill_y1), .FILL_COLOR(fill_color),
    .FILL_BUSY(fill_busy), .FILL_DONE(fill_done),
    .FB_WE(fb_we), .FB_WA1(fb_wa1), .FB_WD(fb_wd), .FB_RD1(fb_rd1)
  );

  // Framebuffer RAM: synchronous read, data valid the cycle after the address edge.
  logic [CW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (fb_we) ram[fb_wa1] <= fb_wd;
    fb_rd1 <= ram[fb_wa1];
  end

  int n_pass = 0, n_tot = 0;
  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Model: fill becomes a queue of pending pixel addresses; MCU has priority each edge.
  logic [CW-1:0] mmem [0:(1<<AW)-1];
  int pix_q[$];
  int fcol = 0, rd_left = 0, rd_val = 0;
  bit mbusy = 0, fin_p = 0, blocked = 0, was_busy = 0;
  bit e_ack = 0, e_we = 0, e_valid = 0, e_done = 0, e_busy = 0;
  int e_addr = 0, e_wd = 0, e_rd = 0;
  int mx0, mx1, my0, my1, pa;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_q.delete();
      mbusy = 0; fin_p = 0; rd_left = 0;
      e_ack = 0; e_we = 0; e_valid = 0; e_done = 0; e_busy = 0;
      e_addr = 0; e_wd = 0; e_rd = 0;
    end else begin
      e_ack = 0; e_we = 0; e_valid = 0; e_done = 0;
      was_busy = mbusy;
      blocked = (rd_left > 0);
      if (rd_left > 0) begin
        rd_left--;
        if (rd_left == 0) begin e_valid = 1; e_rd = rd_val; end
      end
      if (fin_p) begin fin_p = 0; mbusy = 0; e_done = 1; end
      if (fill_start && !was_busy) begin
        mx0 = (fill_x0 > 159) ? 159 : int'(fill_x0);
        mx1 = (fill_x1 > 159) ? 159 : int'(fill_x1);
        my0 = (fill_y0 > 119) ? 119 : int'(fill_y0);
        my1 = (fill_y1 > 119) ? 119 : int'(fill_y1);
        if (mx0 > mx1 || my0 > my1) e_done = 1;
        else begin
          for (int y = my0; y <= my1; y++)
            for (int x = mx0; x <= mx1; x++) pix_q.push_back(y * 256 + x);
          mbusy = 1;
          fcol = int'(fill_color);
        end
      end
      if (!blocked && mcu_req) begin
        e_ack = 1;
        e_addr = int'(mcu_y) * 256 + int'(mcu_x);
        if (mcu_we) begin
          if (mcu_x < 160 && mcu_y < 120) begin
            e_we = 1; e_wd = int'(mcu_wd); mmem[e_addr] = mcu_wd;
          end
        end else begin
          rd_left = 2;
          rd_val = (mcu_x < 160 && mcu_y < 120) ? int'(mmem[e_addr]) : 0;
        end
      end else if (!blocked && pix_q.size() > 0) begin
        pa = pix_q.pop_front();
        e_we = 1; e_addr = pa; e_wd = fcol; mmem[pa] = fcol[CW-1:0];
        if (pix_q.size() == 0) fin_p = 1;
      end
      e_busy = mbusy;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("ack", int'(mcu_ack), int'(e_ack));
      chk("fb_we", int'(fb_we), int'(e_we));
      chk("rd_valid", int'(mcu_rd_valid), int'(e_valid));
      chk("fill_busy", int'(fill_busy), int'(e_busy));
      chk("fill_done", int'(fill_done), int'(e_done));
      if (e_ack || e_we) chk("fb_wa1", int'(fb_wa1), e_addr);
      if (e_we) chk("fb_wd", int'(fb_wd), e_wd);
      if (e_valid) chk("mcu_rd", int'(mcu_rd), e_rd);
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int wlog[$];
  int done_cnt = 0, busy_cnt = 0, last_done = -1, last_valid = -1, last_rd = -1;
  always @(negedge clk) begin
    if (rst_n) begin
      if (fb_we) wlog.push_back(int'(fb_wa1));
      if (fill_done) begin done_cnt++; last_done = cyc; end
      if (fill_busy) busy_cnt++;
      if (mcu_rd_valid) begin last_valid = cyc; last_rd = int'(mcu_rd); end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wlog.delete();
    done_cnt = 0; busy_cnt = 0; last_done = -1; last_valid = -1; last_rd = -1;
  endtask

  task automatic do_fill(input int x0, input int x1, input int y0, input int y1,
                         input int c, output int e);
    fill_x0 = x0[7:0]; fill_x1 = x1[7:0]; fill_y0 = y0[6:0]; fill_y1 = y1[6:0];
    fill_color = c[CW-1:0];
    fill_start = 1'b1;
    step();
    e = cyc;
    fill_start = 1'b0;
    mcu_req = 1'b0;
  endtask

  task automatic set_mcu(input bit we, input int x, input int y, input int wd);
    mcu_req = 1'b1; mcu_we = we; mcu_x = x[7:0]; mcu_y = y[6:0]; mcu_wd = wd[CW-1:0];
  endtask

  int e0;
  int exp2[6] = '{'h0A02, 'h0A03, 'h0A04, 'h0B02, 'h0B03, 'h0B04};
  int exp3[7] = '{'h0A02, 'h0A03, 'h3214, 'h0A04, 'h0B02, 'h0B03, 'h0B04};

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin ram[i] = '0; mmem[i] = '0; end
    ram['h7805] = 12'h555;
    repeat (3) step();
    chk("rst_fb_we", int'(fb_we), 0);
    chk("rst_fb_wa1", int'(fb_wa1), 0);
    chk("rst_fb_wd", int'(fb_wd), 0);
    chk("rst_ack", int'(mcu_ack), 0);
    chk("rst_busy", int'(fill_busy), 0);
    chk("rst_done", int'(fill_done), 0);
    chk("rst_rd_valid", int'(mcu_rd_valid), 0);
    rst_n = 1'b1;
    step();

    // 1: MCU write then read-back
    set_mcu(1, 5, 3, 'hABC);
    step();
    mcu_req = 1'b0;
    chk("t1_we", int'(fb_we), 1);
    chk("t1_wa1", int'(fb_wa1), 'h0305);
    chk("t1_ack", int'(mcu_ack), 1);
    step();
    clear_logs();
    set_mcu(0, 5, 3, 0);
    step();
    e0 = cyc;
    mcu_req = 1'b0;
    repeat (4) step();
    chk("t1_rd_lat", last_valid - e0, 2);
    chk("t1_rd_data", last_rd, 'hABC);

    // 2: uncontended 3x2 fill
    clear_logs();
    do_fill(2, 4, 10, 11, 'hF00, e0);
    repeat (10) step();
    chk("t2_nwr", wlog.size(), 6);
    foreach (exp2[i]) if (i < wlog.size()) chk("t2_addr", wlog[i], exp2[i]);
    chk("t2_done_lat", last_done - e0, 6);
    chk("t2_done_cnt", done_cnt, 1);
    chk("t2_busy_cyc", busy_cnt, 6);

    // 3: same fill, MCU write wins the third fill slot
    clear_logs();
    do_fill(2, 4, 10, 11, 'hF00, e0);
    step();
    set_mcu(1, 20, 50, 'h0F0);
    step();
    mcu_req = 1'b0;
    repeat (10) step();
    chk("t3_nwr", wlog.size(), 7);
    foreach (exp3[i]) if (i < wlog.size()) chk("t3_addr", wlog[i], exp3[i]);
    chk("t3_done_lat", last_done - e0, 7);
    chk("t3_busy_cyc", busy_cnt, 7);

    // 4: clamped fill, then inverted bounds
    clear_logs();
    do_fill(150, 200, 119, 127, 'h00F, e0);
    repeat (14) step();
    chk("t4_nwr", wlog.size(), 10);
    if (wlog.size() > 0) chk("t4_last_addr", wlog[wlog.size()-1], 'h779F);
    chk("t4_done_lat", last_done - e0, 10);
    clear_logs();
    do_fill(9, 3, 0, 0, 'h0AA, e0);
    repeat (4) step();
    chk("t4b_done_lat", last_done - e0, 0);
    chk("t4b_nwr", wlog.size(), 0);
    chk("t4b_busy_cyc", busy_cnt, 0);

    // 5: out-of-range MCU accesses
    clear_logs();
    set_mcu(1, 160, 0, 'h123);
    step();
    mcu_req = 1'b0;
    chk("t5_ack", int'(mcu_ack), 1);
    chk("t5_we", int'(fb_we), 0);
    step();
    set_mcu(0, 5, 120, 0);
    step();
    e0 = cyc;
    mcu_req = 1'b0;
    repeat (4) step();
    chk("t5_rd_lat", last_valid - e0, 2);
    chk("t5_rd_data", last_rd, 0);

    // 6: reset in the middle of a fill
    clear_logs();
    do_fill(0, 9, 0, 0, 'h777, e0);
    step();
    chk("t6_pre_nwr", wlog.size(), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_we", int'(fb_we), 0);
    chk("t6_rst_busy", int'(fill_busy), 0);
    chk("t6_rst_wa1", int'(fb_wa1), 0);
    chk("t6_rst_wd", int'(fb_wd), 0);
    clear_logs();
    step();
    step();
    rst_n = 1'b1;
    repeat (12) step();
    chk("t6_no_done", done_cnt, 0);
    chk("t6_no_wr", wlog.size(), 0);
    do_fill(1, 2, 5, 5, 'h0CC, e0);
    repeat (5) step();
    chk("t6_nwr", wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk("t6_addr0", wlog[0], 'h0501);
      chk("t6_addr1", wlog[1], 'h0502);
    end
    chk("t6_done_lat", last_done - e0, 2);

    // 7: fill start and MCU write on the same edge from IDLE
    clear_logs();
    set_mcu(1, 1, 1, 'h321);
    do_fill(7, 7, 7, 7, 'h123, e0);
    repeat (5) step();
    chk("t7_nwr", wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk("t7_addr0", wlog[0], 'h0101);
      chk("t7_addr1", wlog[1], 'h0707);
    end
    chk("t7_done_lat", last_done - e0, 2);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
